// File: rtl/program_loader.sv
// program_loader: buffers a host byte stream (up to DEPTH bytes) and then
// feeds it to the CPU programming port, one byte per cpu_ready pulse.
module program_loader #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       cpu_ready,
  input  logic       cpu_done,
  output logic       programming,
  output logic [7:0] prog_data,
  output logic       busy,
  output logic       loaded,
  output logic       error,
  output logic [4:0] sent_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFill  = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StError = 3'd4;

  localparam logic [4:0] DepthC   = 5'(DEPTH);
  localparam logic [7:0] TimeoutC = 8'(TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [4:0] wr_cnt_q, wr_cnt_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] mem_q [DEPTH];
  logic       wr_en;
  logic       fill_clr;

  assign in_ready    = (state_q == StFill) && (wr_cnt_q < DepthC);
  assign wr_en       = in_ready && in_valid;
  assign programming = (state_q == StLoad);
  assign busy        = (state_q == StFill) || (state_q == StLoad);
  assign loaded      = (state_q == StDone);
  assign error       = (state_q == StError);
  // Every byte handed over advances the read pointer, so the two are the same count.
  assign sent_count  = rd_ptr_q;

  // Next-state, pointer and stall-counter logic.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    tmo_d    = '0;
    fill_clr = 1'b0;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d  = StFill;
          wr_cnt_d = '0;
          rd_ptr_d = '0;
          fill_clr = 1'b1;
        end
      end
      StFill: begin
        if (wr_en) wr_cnt_d = wr_cnt_q + 5'd1;
        // A byte accepted together with start is stored before moving on.
        if (start || (wr_en && (wr_cnt_q == DepthC - 5'd1))) state_d = StLoad;
      end
      StLoad: begin
        if (cpu_ready) tmo_d = '0;
        else if (tmo_q != TimeoutC) tmo_d = tmo_q + 8'd1;
        else tmo_d = tmo_q;
        if (cpu_ready && (rd_ptr_q != DepthC)) rd_ptr_d = rd_ptr_q + 5'd1;
        // cpu_done wins: a byte taken on the same edge is still counted.
        if (cpu_done) state_d = StDone;
        else if (cpu_ready) begin
          if (rd_ptr_q == DepthC) state_d = StError;
        end else if (tmo_d == TimeoutC) state_d = StError;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= StIdle;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Image buffer: zeroed on FILL entry so a short image is padded with 0x00.
  always_ff @(posedge clk) begin
    if (fill_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_cnt_q == 5'(i)) mem_q[i] <= in_data;
      end
    end
  end

  // Byte presented to the CPU; zero outside LOAD and once the image is exhausted.
  always_comb begin
    prog_data = 8'h00;
    if (state_q == StLoad) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_ptr_q == 5'(i)) prog_data = mem_q[i];
      end
    end
  end

endmodule
